// File: rtl/uart_alu_ctrl_if.sv
// uart_alu_ctrl_if -- bundles the UART byte channel and the ALU operand/result
// bus seen by uart_alu_ctrl.
//
// Handshake semantics (the only flow control in this interface):
//   rx side : rx_valid is a one-cycle pulse; rx_data and rx_ferr are
//             meaningful only in that cycle. There is no back-pressure: the
//             consumer either takes the byte in that cycle or it is lost.
//   tx side : the controller raises tx_start with tx_data stable and holds
//             both until it samples tx_busy high (the transmitter has taken
//             the byte). It then drops tx_start and waits for tx_busy to go
//             low before it issues another byte.
//   alu side: alu_a/alu_b/alu_op are registered by the controller;
//             alu_result/alu_carry/alu_zero are combinational from the ALU.
//
// master : the controller (uart_alu_ctrl)
// slave  : the UART + ALU environment around it
interface uart_alu_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    modport master (
        input  rx_data, rx_valid, rx_ferr, tx_busy,
        input  alu_result, alu_carry, alu_zero,
        output tx_start, tx_data,
        output alu_a, alu_b, alu_op
    );

    modport slave (
        output rx_data, rx_valid, rx_ferr, tx_busy,
        output alu_result, alu_carry, alu_zero,
        input  tx_start, tx_data,
        input  alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl -- collects a three-byte command (A, B, opcode) from a UART
// receiver, presents it to an external combinational ALU, and sends the
// result byte back through the UART transmitter.
//
// Optional feature macro: UART_ALU_STATUS_EN. When defined, a second byte
// {6'b0, carry, zero} follows every result byte. When undefined the status
// states and flag registers are not built.
//
// The FSM state is exported on state_dbg (encoding = state_t below) so
// checkers can observe it directly.
module uart_alu_ctrl #(
    parameter int DATA_W         = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_alu_ctrl_if.master        bus,
    output logic                   busy,
    output logic [7:0]             ferr_cnt,
    output logic [2:0]             state_dbg
);

    // Wide enough to hold TIMEOUT_CYCLES-1, the last value before expiry.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_ALU_STATUS_EN
    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        GET_OP   = 3'd2,
        EXEC     = 3'd3,
        SEND_RES = 3'd4,
        WAIT_RES = 3'd5,
        SEND_STS = 3'd6,
        WAIT_STS = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        GET_OP   = 3'd2,
        EXEC     = 3'd3,
        SEND_RES = 3'd4,
        WAIT_RES = 3'd5
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        ferr_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt;

    // Strobes from the FSM to the datapath registers.
    logic              ld_a;
    logic              ld_b;
    logic              ld_op;
    logic              ld_res;
    logic              ferr_hit;
    logic              tmo_clr;
    logic              tmo_inc;
    logic              tmo_hit;
    logic              rx_good;
    logic              rx_bad;

`ifdef UART_ALU_STATUS_EN
    logic              ld_sts;
    logic              sts_carry;
    logic              sts_zero;
`endif

    assign rx_good = bus.rx_valid & ~bus.rx_ferr;
    assign rx_bad  = bus.rx_valid &  bus.rx_ferr;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // FSM state register; reset lands in GET_A immediately (async).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        ld_res    = 1'b0;
        ferr_hit  = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
`ifdef UART_ALU_STATUS_EN
        ld_sts    = 1'b0;
`endif
        case (state)
            GET_A: begin
                // No command in progress, so the inter-byte timer is idle.
                tmo_clr = 1'b1;
                if (rx_bad) begin
                    ferr_hit = 1'b1;
                end else if (rx_good) begin
                    ld_a      = 1'b1;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (rx_bad) begin
                    ferr_hit  = 1'b1;
                    tmo_clr   = 1'b1;
                    state_nxt = GET_A;
                end else if (rx_good) begin
                    ld_b      = 1'b1;
                    tmo_clr   = 1'b1;
                    state_nxt = GET_OP;
                end else if (tmo_hit) begin
                    tmo_clr   = 1'b1;
                    state_nxt = GET_A;
                end else begin
                    tmo_inc   = 1'b1;
                end
            end
            GET_OP: begin
                if (rx_bad) begin
                    ferr_hit  = 1'b1;
                    tmo_clr   = 1'b1;
                    state_nxt = GET_A;
                end else if (rx_good) begin
                    ld_op     = 1'b1;
                    tmo_clr   = 1'b1;
                    state_nxt = EXEC;
                end else if (tmo_hit) begin
                    tmo_clr   = 1'b1;
                    state_nxt = GET_A;
                end else begin
                    tmo_inc   = 1'b1;
                end
            end
            EXEC: begin
                // Operands settled last cycle; capture the ALU output once.
                ld_res    = 1'b1;
                state_nxt = SEND_RES;
            end
            SEND_RES: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (!bus.tx_busy) begin
`ifdef UART_ALU_STATUS_EN
                    ld_sts    = 1'b1;
                    state_nxt = SEND_STS;
`else
                    state_nxt = GET_A;
`endif
                end
            end
`ifdef UART_ALU_STATUS_EN
            SEND_STS: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_STS;
                end
            end
            WAIT_STS: begin
                if (!bus.tx_busy) begin
                    state_nxt = GET_A;
                end
            end
`endif
            default: begin
                state_nxt = GET_A;
            end
        endcase
    end

    // Operand and opcode registers; written only when their byte is accepted
    // so the ALU inputs stay stable through execution and transmission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            if (ld_a) begin
                alu_a_q <= DATA_W'(bus.rx_data);
            end
            if (ld_b) begin
                alu_b_q <= DATA_W'(bus.rx_data);
            end
            if (ld_op) begin
                alu_op_q <= bus.rx_data[OP_W-1:0];
            end
        end
    end

    // Transmit byte: the result on EXEC, then the status byte if enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q <= 8'h00;
        end else begin
            if (ld_res) begin
                tx_data_q <= 8'(bus.alu_result);
            end
`ifdef UART_ALU_STATUS_EN
            if (ld_sts) begin
                tx_data_q <= {6'b0, sts_carry, sts_zero};
            end
`endif
        end
    end

`ifdef UART_ALU_STATUS_EN
    // ALU flags captured together with the result in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sts_carry <= 1'b0;
            sts_zero  <= 1'b0;
        end else if (ld_res) begin
            sts_carry <= bus.alu_carry;
            sts_zero  <= bus.alu_zero;
        end
    end
`endif

    // Framing-error counter, saturating so it never wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr_cnt_q <= 8'h00;
        end else if (ferr_hit && (ferr_cnt_q != 8'hFF)) begin
            ferr_cnt_q <= ferr_cnt_q + 8'h01;
        end
    end

    // Inter-byte timer; restarts on every accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (tmo_clr) begin
            tmo_cnt <= '0;
        end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // tx_start decodes straight from the state so reset removes it at once.
`ifdef UART_ALU_STATUS_EN
    assign bus.tx_start = (state == SEND_RES) || (state == SEND_STS);
`else
    assign bus.tx_start = (state == SEND_RES);
`endif
    assign bus.tx_data  = tx_data_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_op   = alu_op_q;
    assign busy         = (state != GET_A);
    assign ferr_cnt     = ferr_cnt_q;
    assign state_dbg    = state;

endmodule
